// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_add_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/full_adder_1bit.sv
// Single combinational full-adder cell shared by every bit position of the serial adder.
module full_adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_16bit.sv
// Bit-serial 16-bit adder, LSB first, one bit per clock with a start/done handshake.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_16bit
  import serial_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             cout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ov_q, ov_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_init;
  logic             fa_s, fa_c;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff    = sub ? ~B : B;
  assign cin_init = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = B;
  assign cin_init   = 1'b0;
`endif

  full_adder_1bit u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ov_d    = ov_q;
    cout_d  = cout_q;
    if (state_q == S_IDLE && start) begin
      a_d     = A;
      b_d     = b_eff;
      carry_d = cin_init;
      cnt_d   = '0;
    end else if (state_q == S_SHIFT) begin
      a_d     = {1'b0, a_q[WIDTH-1:1]};
      b_d     = {1'b0, b_q[WIDTH-1:1]};
      res_d   = {fa_s, res_q[WIDTH-2:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        // Operand LSBs now hold the original sign bits A[15] and Beff[15].
        sum_d  = {fa_s, res_q};
        cout_d = fa_c;
        ov_d   = (a_q[0] == b_q[0]) && (fa_s != a_q[0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ov_q    <= ov_d;
      cout_q  <= cout_d;
    end
  end

  assign sum      = sum_q;
  assign overflow = ov_q;
  assign cout     = cout_q;

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Scoreboard bench for serial_adder_16bit: driver pushes expected results, monitor checks on done.
module tb_serial_adder_16bit;

  typedef struct packed {
    logic [15:0] s;
    logic        ov;
    logic        co;
  } exp_t;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic        sub;
  logic        busy, done, overflow, cout;
  logic [15:0] sum;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc = 0;
  exp_t sb[$];

  serial_adder_16bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .sub     (sub),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .overflow(overflow),
    .cout    (cout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on whole words.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t        e;
    logic        eff_sub;
    logic [16:0] full;
    int          r;
    eff_sub = s && SubEn;
    if (eff_sub) begin
      full = {1'b0, a} + {1'b0, ~b} + 17'd1;
      r    = int'($signed(a)) - int'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r    = int'($signed(a)) + int'($signed(b));
    end
    e.s  = full[15:0];
    e.co = full[16];
    e.ov = (r > 32767) || (r < -32768);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (busy && done) chk("busy_and_done", 32'(busy & done), 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("cout", 32'(cout), 32'(e.co));
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input bit push);
    @(posedge clk);
    #1;
    A = a; B = b; sub = s; start = 1'b1;
    if (push) sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    else chk("done_latency", 32'(cyc - acc), 32'd16);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s);
    start_op(a, b, s, 1'b1);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; sub = 1'b0;
    #13;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h0001, 16'h0001, 1'b0);
    run(16'h7FFF, 16'h0001, 1'b0);
    run(16'h8000, 16'h8000, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0);
    run(16'h1234, 16'h4321, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run(16'h8000, 16'h0001, 1'b1);
    run(16'h0005, 16'h0007, 1'b1);
`endif

    // A start pulse during SHIFT must be dropped, not queued.
    start_op(16'h1234, 16'h0101, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("idle_after_ignored_start", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation: outputs clear at once and no done follows.
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run(16'h00FF, 16'h0001, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run(16'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
